// File: rtl/rans_renorm_if.sv
// Handshake and data bundle between the rANS renormalizer and its neighbours:
// symbol input, emitted-word stream, modulo-stage output and error pulse.
interface rans_renorm_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_high;
    logic [31:0] x_low;
    logic [31:0] freq;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_out;
    logic        out_valid;
    logic [31:0] x_out_high;
    logic [31:0] x_out_low;
    logic [31:0] z_out_high;
    logic [31:0] z_out_low;
    logic        err;

    modport slave (
        input  in_valid, x_high, x_low, freq, word_ready,
        output in_ready, word_valid, word_out, out_valid,
               x_out_high, x_out_low, z_out_high, z_out_low, err
    );

    modport master (
        output in_valid, x_high, x_low, freq, word_ready,
        input  in_ready, word_valid, word_out, out_valid,
               x_out_high, x_out_low, z_out_high, z_out_low, err
    );
endinterface

// File: rtl/rans_renorm.sv
// rANS encoder renormalization: streams out 32-bit words of x until x < f << (L_LOG2-SCALE_BITS+32),
// then hands the reduced x and divisor f to the downstream modulo stage.
//
// state | meaning
// IDLE  | waiting for a symbol, in_ready high
// CHECK | compare x against x_max
// EMIT  | word_out = x[31:0] offered on the stream, waits for word_ready
// DONE  | publish x_out / z_out, return to IDLE
module rans_renorm #(
    parameter int SCALE_BITS = 12,
    parameter int L_LOG2     = 31
) (
    input logic          clock,
    input logic          reset,
    rans_renorm_if.slave bus
);
    localparam int          XMAX_SHIFT = L_LOG2 - SCALE_BITS + 32;
    localparam logic [32:0] F_LIMIT    = 33'd1 << SCALE_BITS;

    typedef enum logic [1:0] {IDLE, CHECK, EMIT, DONE} state_t;

    state_t      state;
    logic [63:0] x_reg;
    logic [63:0] x_max;
    logic [31:0] f_reg;
    logic        f_bad;

    assign f_bad = (bus.freq == 32'd0) || ({1'b0, bus.freq} > F_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            x_reg          <= '0;
            x_max          <= '0;
            f_reg          <= '0;
            bus.in_ready   <= 1'b0;
            bus.word_valid <= 1'b0;
            bus.word_out   <= '0;
            bus.out_valid  <= 1'b0;
            bus.x_out_high <= '0;
            bus.x_out_low  <= '0;
            bus.z_out_high <= '0;
            bus.z_out_low  <= '0;
            bus.err        <= 1'b0;
        end else begin
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_ready && bus.in_valid) begin
                        // A rejected symbol leaves the block ready for the next one.
                        if (f_bad) begin
                            bus.err <= 1'b1;
                        end else begin
                            x_reg        <= {bus.x_high, bus.x_low};
                            f_reg        <= bus.freq;
                            x_max        <= 64'(bus.freq) << XMAX_SHIFT;
                            bus.in_ready <= 1'b0;
                            state        <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (x_reg >= x_max) begin
                        bus.word_valid <= 1'b1;
                        bus.word_out   <= x_reg[31:0];
                        state          <= EMIT;
                    end else begin
                        state <= DONE;
                    end
                end
                EMIT: begin
                    if (bus.word_ready) begin
                        bus.word_valid <= 1'b0;
                        x_reg          <= x_reg >> 32;
                        state          <= CHECK;
                    end
                end
                DONE: begin
                    bus.out_valid  <= 1'b1;
                    bus.x_out_high <= x_reg[63:32];
                    bus.x_out_low  <= x_reg[31:0];
                    bus.z_out_high <= '0;
                    bus.z_out_low  <= f_reg;
                    bus.in_ready   <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rans_renorm.sv
// Self-checking bench for rans_renorm: directed spec cases plus randomized symbols
// compared against an arithmetic model of rANS renormalization.
module tb_rans_renorm;
    localparam int SCALE_BITS = 12;
    localparam int L_LOG2     = 31;

    logic clock;
    logic reset;
    rans_renorm_if bus();

    rans_renorm #(.SCALE_BITS(SCALE_BITS), .L_LOG2(L_LOG2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int fails  = 0;

    // Observations of one symbol, filled by do_symbol.
    logic [31:0] cap_words[$];
    logic [31:0] exp_words[$];
    int          cap_out_cycle;
    int          cap_out_count;
    logic [63:0] cap_x_out;
    logic [31:0] cap_z_hi;
    logic [31:0] cap_z_lo;
    int          cap_err;
    int          cap_err_cycle;
    int          cap_stalls;
    bit          cap_overlap;
    bit          cap_unstable;
    bit          cap_ready_timeout;
    logic        cap_ready_end;

    // Renormalization from the definition: emit low words while x >= f * 2^(L_LOG2-SCALE_BITS+32).
    function automatic int model(input logic [63:0] x, input logic [31:0] f, output logic [63:0] xo);
        logic [63:0] lim;
        int k;
        lim = 64'(f) * (64'd1 << (L_LOG2 - SCALE_BITS + 32));
        exp_words.delete();
        k = 0;
        while (x >= lim) begin
            exp_words.push_back(x[31:0]);
            x = x / 64'h1_0000_0000;
            k++;
        end
        xo = x;
        return k;
    endfunction

    // mode 0: word_ready always 1; mode 1: random stalls; mode 2: first 5 EMIT cycles stalled.
    // Cycle n is the cycle after edge E(n), E0 being the acceptance edge.
    task automatic do_symbol(input logic [63:0] x, input logic [31:0] f, input int mode, input int budget);
        int n;
        bit stall;
        bit prev_stall;
        logic [31:0] prev_word;
        cap_words.delete();
        cap_out_cycle = -1; cap_out_count = 0; cap_x_out = '0; cap_z_hi = '0; cap_z_lo = '0;
        cap_err = 0; cap_err_cycle = -1; cap_stalls = 0;
        cap_overlap = 0; cap_unstable = 0; cap_ready_timeout = 0;
        bus.word_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            cap_ready_timeout = 1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.x_high   = x[63:32];
        bus.x_low    = x[31:0];
        bus.freq     = f;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 0;
        prev_stall = 0;
        prev_word = '0;
        while (n <= budget) begin
            if (prev_stall && (!bus.word_valid || bus.word_out !== prev_word)) cap_unstable = 1;
            if (bus.err) begin
                cap_err++;
                cap_err_cycle = n;
            end
            if (bus.word_valid && bus.out_valid) cap_overlap = 1;
            if (bus.out_valid) begin
                cap_out_count++;
                if (cap_out_cycle < 0) begin
                    cap_out_cycle = n;
                    cap_x_out = {bus.x_out_high, bus.x_out_low};
                    cap_z_hi  = bus.z_out_high;
                    cap_z_lo  = bus.z_out_low;
                end
            end
            if (bus.word_valid) begin
                case (mode)
                    1:       stall = ($urandom_range(0, 2) == 0);
                    2:       stall = (cap_stalls < 5);
                    default: stall = 0;
                endcase
                bus.word_ready = !stall;
                if (stall) cap_stalls++;
                else cap_words.push_back(bus.word_out);
                prev_stall = stall;
                prev_word  = bus.word_out;
            end else begin
                bus.word_ready = 1'b1;
                prev_stall = 0;
            end
            if (cap_out_cycle >= 0 && n >= cap_out_cycle + 1) break;
            @(negedge clock);
            n++;
        end
        bus.word_ready = 1'b1;
        cap_ready_end = bus.in_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL reset_word_valid: got %b want 0", bus.word_valid); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++;
        if ({bus.word_out, bus.x_out_high, bus.x_out_low, bus.z_out_high, bus.z_out_low} !== 160'd0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h %h %h want all 0", bus.word_out, bus.x_out_high, bus.x_out_low, bus.z_out_high, bus.z_out_low);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL release_in_ready_early: got %b want 0", bus.in_ready); end
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_no_emit();
        do_symbol(64'h0000_0000_8000_0000, 32'd3, 0, 20);
        checks++; if (cap_words.size() != 0) begin fails++; $display("FAIL no_emit_words: got %0d want 0", cap_words.size()); end
        checks++; if (cap_out_cycle != 2) begin fails++; $display("FAIL no_emit_latency: got %0d want 2", cap_out_cycle); end
        checks++; if (cap_x_out !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL no_emit_x_out: got %h want 0000000080000000", cap_x_out); end
        checks++; if ({cap_z_hi, cap_z_lo} !== {32'd0, 32'd3}) begin fails++; $display("FAIL no_emit_z_out: got %h_%h want 0_3", cap_z_hi, cap_z_lo); end
        checks++; if (cap_out_count != 1) begin fails++; $display("FAIL no_emit_pulse_width: got %0d want 1", cap_out_count); end
    endtask

    task automatic test_one_emit();
        do_symbol(64'h0020_0000_1234_5678, 32'd3, 0, 20);
        checks++; if (cap_words.size() != 1) begin fails++; $display("FAIL one_emit_count: got %0d want 1", cap_words.size()); end
        checks++;
        if (cap_words.size() == 0 || cap_words[0] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL one_emit_word: got %h want 12345678", (cap_words.size() == 0) ? 32'hx : cap_words[0]);
        end
        checks++; if (cap_out_cycle != 4) begin fails++; $display("FAIL one_emit_latency: got %0d want 4", cap_out_cycle); end
        checks++; if (cap_x_out !== 64'h0000_0000_0020_0000) begin fails++; $display("FAIL one_emit_x_out: got %h want 0000000000200000", cap_x_out); end
        checks++; if (cap_z_lo !== 32'd3) begin fails++; $display("FAIL one_emit_z_out: got %0d want 3", cap_z_lo); end
    endtask

    task automatic test_backpressure();
        do_symbol(64'h0020_0000_1234_5678, 32'd3, 2, 30);
        checks++; if (cap_stalls != 5) begin fails++; $display("FAIL bp_stalls: got %0d want 5", cap_stalls); end
        checks++; if (cap_unstable !== 1'b0) begin fails++; $display("FAIL bp_word_stable: got unstable=%b want 0", cap_unstable); end
        checks++;
        if (cap_words.size() != 1 || cap_words[0] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL bp_word: got count %0d want 1 word 12345678", cap_words.size());
        end
        checks++; if (cap_out_cycle != 9) begin fails++; $display("FAIL bp_latency: got %0d want 9", cap_out_cycle); end
    endtask

    task automatic test_freq_bounds();
        do_symbol(64'h0000_0000_8000_0000, 32'd0, 0, 8);
        checks++; if (cap_err != 1 || cap_err_cycle != 0) begin fails++; $display("FAIL f0_err: got %0d pulses at %0d want 1 at 0", cap_err, cap_err_cycle); end
        checks++; if (cap_out_cycle != -1 || cap_words.size() != 0) begin fails++; $display("FAIL f0_outputs: got out_cycle %0d words %0d want none", cap_out_cycle, cap_words.size()); end
        checks++; if (cap_ready_end !== 1'b1) begin fails++; $display("FAIL f0_ready: got %b want 1", cap_ready_end); end
        do_symbol(64'h0000_0000_8000_0000, 32'd4097, 0, 8);
        checks++; if (cap_err != 1) begin fails++; $display("FAIL f4097_err: got %0d want 1", cap_err); end
        checks++; if (cap_out_cycle != -1) begin fails++; $display("FAIL f4097_out: got %0d want -1", cap_out_cycle); end
        do_symbol(64'h0000_0000_8000_0000, 32'd4096, 0, 20);
        checks++; if (cap_err != 0) begin fails++; $display("FAIL f4096_err: got %0d want 0", cap_err); end
        checks++; if (cap_out_cycle != 2 || cap_z_lo !== 32'd4096) begin fails++; $display("FAIL f4096_out: got cycle %0d z %0d want 2 4096", cap_out_cycle, cap_z_lo); end
        checks++; if (cap_x_out !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL f4096_x_out: got %h want 0000000080000000", cap_x_out); end
    endtask

    task automatic test_reset_mid_emit();
        int n;
        int stale;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clock); n++; end
        bus.word_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.x_high = 32'h0020_0000;
        bus.x_low  = 32'h1234_5678;
        bus.freq   = 32'd3;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.word_valid && n < 10) begin @(negedge clock); n++; end
        checks++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL mid_reset_reach_emit: got word_valid %b want 1", bus.word_valid); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.word_valid, bus.out_valid, bus.err} !== 4'b0 ||
            {bus.word_out, bus.x_out_high, bus.x_out_low, bus.z_out_high, bus.z_out_low} !== 160'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got ctrl %b word %h want all 0",
                     {bus.in_ready, bus.word_valid, bus.out_valid, bus.err}, bus.word_out);
        end
        bus.word_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b want 1", bus.in_ready); end
        stale = 0;
        repeat (10) begin
            if (bus.out_valid || bus.word_valid) stale++;
            @(negedge clock);
        end
        checks++; if (stale != 0) begin fails++; $display("FAIL mid_reset_stale: got %0d active cycles want 0", stale); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] x2;
        logic [31:0] f2;
        logic [63:0] xo2;
        int k2;
        int n;
        int ocyc[$];
        logic [63:0] oxs[$];
        logic [31:0] ozs[$];
        logic rdy2;
        logic rdy3;
        logic [31:0] words[$];
        bit wbad;
        x2 = {$urandom, $urandom};
        f2 = $urandom_range(1, 4096);
        k2 = model(x2, f2, xo2);
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clock); n++; end
        bus.word_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_high = 32'h0;
        bus.x_low  = 32'h8000_0000;
        bus.freq   = 32'd3;
        @(posedge clock);
        @(negedge clock);
        bus.x_high = x2[63:32];
        bus.x_low  = x2[31:0];
        bus.freq   = f2;
        rdy2 = 1'bx;
        rdy3 = 1'bx;
        for (n = 0; n < 40 && ocyc.size() < 2; n++) begin
            if (n == 2) rdy2 = bus.in_ready;
            if (n == 3) begin
                rdy3 = bus.in_ready;
                bus.in_valid = 1'b0;
            end
            if (bus.word_valid) words.push_back(bus.word_out);
            if (bus.out_valid) begin
                ocyc.push_back(n);
                oxs.push_back({bus.x_out_high, bus.x_out_low});
                ozs.push_back(bus.z_out_low);
            end
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        checks++; if (rdy2 !== 1'b1 || rdy3 !== 1'b0) begin fails++; $display("FAIL b2b_accept_e3: got ready %b/%b want 1/0", rdy2, rdy3); end
        checks++;
        if (ocyc.size() != 2) begin
            fails++;
            $display("FAIL b2b_out_count: got %0d want 2", ocyc.size());
        end else begin
            if (ocyc[0] != 2 || oxs[0] !== 64'h8000_0000 || ozs[0] !== 32'd3) begin
                fails++;
                $display("FAIL b2b_first: got cycle %0d x %h z %0d want 2 0000000080000000 3", ocyc[0], oxs[0], ozs[0]);
            end
            checks++;
            if (ocyc[1] != 5 + 2 * k2 || oxs[1] !== xo2 || ozs[1] !== f2) begin
                fails++;
                $display("FAIL b2b_second: got cycle %0d x %h z %0d want %0d %h %0d", ocyc[1], oxs[1], ozs[1], 5 + 2 * k2, xo2, f2);
            end
        end
        wbad = (words.size() != exp_words.size());
        foreach (words[i]) if (!wbad && words[i] !== exp_words[i]) wbad = 1;
        checks++; if (wbad) begin fails++; $display("FAIL b2b_words: got %0d words want %0d", words.size(), exp_words.size()); end
    endtask

    task automatic test_random();
        logic [63:0] x;
        logic [31:0] f;
        logic [63:0] xo;
        int k;
        bit wbad;
        for (int s = 0; s < 25; s++) begin
            x = {$urandom, $urandom} >> $urandom_range(0, 40);
            f = $urandom_range(1, 4096);
            k = model(x, f, xo);
            do_symbol(x, f, 1, 80);
            checks++;
            if (cap_out_cycle != 2 + 2 * k + cap_stalls || cap_out_count != 1) begin
                fails++;
                $display("FAIL rand_latency[%0d]: got cycle %0d count %0d want %0d 1", s, cap_out_cycle, cap_out_count, 2 + 2 * k + cap_stalls);
            end
            checks++;
            if (cap_x_out !== xo || cap_z_hi !== 32'd0 || cap_z_lo !== f) begin
                fails++;
                $display("FAIL rand_result[%0d]: got x %h z %h_%h want x %h z 0_%h", s, cap_x_out, cap_z_hi, cap_z_lo, xo, f);
            end
            wbad = (cap_words.size() != exp_words.size());
            foreach (cap_words[i]) if (!wbad && cap_words[i] !== exp_words[i]) wbad = 1;
            checks++;
            if (wbad) begin
                fails++;
                $display("FAIL rand_words[%0d]: got %0d words want %0d", s, cap_words.size(), exp_words.size());
            end
            checks++;
            if (cap_overlap || cap_unstable || cap_err != 0) begin
                fails++;
                $display("FAIL rand_protocol[%0d]: got overlap %b unstable %b err %0d want 0 0 0", s, cap_overlap, cap_unstable, cap_err);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.x_high = '0;
        bus.x_low = '0;
        bus.freq = '0;
        bus.word_ready = 1'b1;
        test_reset();
        test_no_emit();
        test_one_emit();
        test_backpressure();
        test_freq_bounds();
        test_back_to_back();
        test_random();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rans_renorm.md
RANS_RENORM -- requirements
Module: rans_renorm

Interface
REQ-001 Parameter SCALE_BITS, default 12: log2 of the frequency table total M.
REQ-002 Parameter L_LOG2, default 31: log2 of the rANS lower state bound L.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; 0 SHALL reset immediately, independent of clock.
REQ-005 Port in_valid, input, 1: x_high, x_low and freq are valid this cycle.
REQ-006 Port in_ready, output, 1: block accepts a new symbol this cycle.
REQ-007 Port x_high, input, 32: upper half of the 64-bit rANS state x.
REQ-008 Port x_low, input, 32: lower half of x.
REQ-009 Port freq, input, 32: symbol frequency f.
REQ-010 Port word_valid, output, 1: word_out holds an emitted stream word.
REQ-011 Port word_ready, input, 1: stream sink accepts word_out.
REQ-012 Port word_out, output, 32: emitted word, equal to x[31:0].
REQ-013 Port out_valid, output, 1: one-cycle pulse; the x_out and z_out ports are valid and feed the downstream modulo stage.
REQ-014 Port x_out_high / x_out_low, output, 32 each: renormalized x.
REQ-015 Port z_out_high / z_out_low, output, 32 each: divisor for the modulo stage; z_out_high SHALL be 0 and z_out_low SHALL be f.
REQ-016 Port err, output, 1: one-cycle pulse when a symbol is rejected.

Function
REQ-017 FSM states: IDLE, CHECK, EMIT, DONE.
- in_ready SHALL be 1 only in IDLE.
- in_valid SHALL be ignored outside IDLE.
REQ-018 IDLE, in_valid=1:
- Latch x = {x_high, x_low} and f.
- Compute x_max = f << (L_LOG2 - SCALE_BITS + 32) as a 64-bit value.
- Go to CHECK.
REQ-019 On acceptance with f==0 or f > 2^SCALE_BITS:
- Pulse err for exactly one cycle.
- Produce no word and no out_valid.
- Remain in IDLE.
REQ-020 CHECK: if x >= x_max (unsigned 64-bit), go to EMIT; otherwise go to DONE.
REQ-021 EMIT:
- word_valid=1 and word_out=x[31:0].
- On a cycle with word_ready=1, set x <= x >> 32 (zero-fill) and go to CHECK.
- With word_ready=0, hold state; word_out and word_valid SHALL stay stable.
REQ-022 DONE:
- out_valid=1 for exactly one cycle, with x_out = latched x and z_out_low = f.
- Go to IDLE.
REQ-023 Latency, with acceptance at edge E0 and word_ready held at 1:
- k emitted words: out_valid high in the cycle after edge E(2+2k).
- Next acceptance possible at edge E(3+2k).
REQ-024 The EMIT/CHECK loop SHALL repeat until x < x_max, with no limit on iteration count.
REQ-025 word_valid and out_valid SHALL never be high in the same cycle.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-027 While reset=0, outputs SHALL take these values:
- FSM = IDLE.
- in_ready, word_valid, out_valid, err = 0.
- word_out, x_out_high, x_out_low, z_out_high, z_out_low = 0.
REQ-028 in_ready SHALL rise on the first rising clock edge after reset deasserts.
REQ-029 Reset asserted in any state, including mid-EMIT, SHALL abort the symbol.
- No out_valid for that symbol SHALL appear after release.

Verification
REQ-030 No-emit case. Defaults, x=0x0000_0000_8000_0000, f=3, word_ready=1:
- No word_valid.
- out_valid in the cycle after E2.
- x_out=0x0000_0000_8000_0000, z_out_low=3.
REQ-031 One-emit case. x=0x0020_0000_1234_5678, f=3:
- word_out=0x1234_5678.
- Then out_valid with x_out=0x0000_0000_0020_0000, z_out_low=3, in the cycle after E4.
REQ-032 Backpressure. Same stimulus as REQ-031, word_ready=0 for 5 cycles in EMIT:
- word_valid stays 1 and word_out stays 0x1234_5678 throughout.
- out_valid is delayed by exactly 5 cycles.
REQ-033 Frequency bounds:
- f=0 -> err pulse, no outputs.
- f=4097 -> err pulse.
- f=4096 with x=0x0000_0000_8000_0000 -> normal out_valid.
REQ-034 Reset mid-operation. Reset low during EMIT of the REQ-031 symbol:
- All outputs go to 0 immediately.
- in_ready=1 one edge after release.
- No stale out_valid.
REQ-035 Back-to-back symbols with in_valid held high:
- Second symbol accepted at E3 after the first no-emit symbol.
- Outputs appear in order with correct x and f.
